// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: requester index, error codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    localparam int MEM_ARB_MAX_REQ = 4;
    localparam int REQ_IDX_W = ($clog2(MEM_ARB_MAX_REQ) < 1) ? 1 : $clog2(MEM_ARB_MAX_REQ);

    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    typedef enum logic {
        ERR_NONE         = 1'b0,
        ERR_SPURIOUS_RSP = 1'b1
    } arb_err_e;

endpackage

// File: rtl/mem_arbiter_tag_fifo.sv
// In-order tag FIFO remembering which requester owns each outstanding read.
// Latency: push visible at dout one cycle later; dout is the combinational head.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory request port between NUM_REQ requesters; routes read data back by tag.
// Latency: grant in cycle N -> mem_valid with that payload in N+1; mem_rsp_valid in N -> rsp_valid in N+1.
// Backpressure: no grant while the output slot is held or (reads only) the tag FIFO is full; MEM_ARB_FIXED_PRIO_EN selects fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        mem_valid,
    input  logic                        mem_ready,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_rsp_valid,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        err_out
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic               slot_free;
    logic               tag_pop;
    logic               tag_push;
    logic               tag_room;
    logic               tag_full;
    logic               tag_empty;
    logic               spurious;
    req_idx_t           tag_dout;
    logic [CNT_W-1:0]   tag_count;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] rsp_hit;
    logic               grant_vld;
    req_idx_t           winner;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    arb_err_e           err_state;

    assign slot_free = !mem_valid || mem_ready;
    assign tag_pop   = mem_rsp_valid && !tag_empty;
    assign spurious  = mem_rsp_valid && (tag_count == '0);
    // A response popping this cycle makes room for a read granted in the same cycle.
    assign tag_room  = !tag_full || tag_pop;
    assign tag_push  = grant_vld && !sel_we;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = !rst_in && req_valid[i] && slot_free && (req_we[i] || tag_room);
        end
    end

`ifdef MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_vld = 1'b0;
        winner    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant_vld = 1'b1;
                winner    = req_idx_t'(i);
            end
        end
    end
`else
    req_idx_t rr;

    // Walk offsets from farthest to nearest so the first eligible after rr is left standing.
    always_comb begin
        grant_vld = 1'b0;
        winner    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((((int'(rr) + k) % NUM_REQ) == i) && eligible[i]) begin
                    grant_vld = 1'b1;
                    winner    = req_idx_t'(i);
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)         rr <= '0;
        else if (grant_vld) rr <= winner;
    end
`endif

    always_comb begin
        grant     = '0;
        rsp_hit   = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i]   = grant_vld && (winner == req_idx_t'(i));
            rsp_hit[i] = tag_pop && (tag_dout == req_idx_t'(i));
            if (grant[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign req_ready = grant;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_vld) begin
            mem_valid <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
        end else if (mem_ready) begin
            mem_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= rsp_hit;
            if (tag_pop) rsp_rdata <= mem_rdata;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)        err_state <= ERR_NONE;
        else if (spurious) err_state <= ERR_SPURIOUS_RSP;
    end

    assign err_out = (err_state == ERR_SPURIOUS_RSP);

    tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     ($bits(req_idx_t))
    ) u_tag_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (tag_push),
        .pop    (tag_pop),
        .din    (winner),
        .dout   (tag_dout),
        .full   (tag_full),
        .empty  (tag_empty),
        .count  (tag_count)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int NR = 2;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MO = 4;
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_we;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_rsp_valid;
    logic [DW-1:0]     mem_rdata;
    logic              err_out;

    always #5 clk_in = ~clk_in;

    mem_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .err_out(err_out)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: transaction-level view of the arbiter.
    bit             m_mv;
    bit             m_we;
    logic [AW-1:0]  m_addr;
    logic [DW-1:0]  m_wdata;
    logic [NR-1:0]  m_rsp;
    logic [DW-1:0]  m_rdata;
    bit             m_err;
    int             m_last;
    int             tagq[$];
    int             pend_n;

    logic [NR-1:0]  last_ready;
    logic [NR-1:0]  last_rsp;
    logic [DW-1:0]  last_rdata;
    logic [AW-1:0]  last_addr;
    logic [DW-1:0]  last_wdata;
    logic           last_we;
    logic           last_mv;
    logic           last_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mv = 0; m_we = 0; m_addr = '0; m_wdata = '0;
        m_rsp = '0; m_rdata = '0; m_err = 0; m_last = 0;
        tagq.delete();
        pend_n = 0;
    endtask

    function automatic int pick();
        int  sz;
        int  c;
        bit  popping;
        sz = tagq.size();
        popping = mem_rsp_valid && (sz > 0);
        if (m_mv && !mem_ready) return -1;
        for (int off = 1; off <= NR; off++) begin
            c = FIXED ? off - 1 : (m_last + off) % NR;
            if (req_valid[c] && (req_we[c] || (sz - int'(popping)) < MO)) return c;
        end
        return -1;
    endfunction

    task automatic cycle();
        int            w;
        int            h;
        logic [NR-1:0] exp_ready;
        @(negedge clk_in);
        w = pick();
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        last_ready = req_ready; last_rsp = rsp_valid; last_rdata = rsp_rdata;
        last_addr = mem_addr; last_wdata = mem_wdata; last_we = mem_we;
        last_mv = mem_valid; last_err = err_out;
        chk("req_ready", req_ready, exp_ready);
        chk("mem_valid", mem_valid, m_mv);
        chk("rsp_valid", rsp_valid, m_rsp);
        chk("err_out", err_out, m_err);
        if (m_mv) begin
            chk("mem_we", mem_we, m_we);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
        if (m_rsp != '0) chk("rsp_rdata", rsp_rdata, m_rdata);
        if (m_mv && mem_ready && !m_we) pend_n++;
        m_rsp = '0;
        if (mem_rsp_valid) begin
            if (tagq.size() > 0) begin
                h = tagq.pop_front();
                m_rsp[h] = 1'b1;
                m_rdata = mem_rdata;
            end else begin
                m_err = 1;
            end
        end
        if (w >= 0) begin
            m_mv = 1;
            m_we = req_we[w];
            m_addr = req_addr[w*AW +: AW];
            m_wdata = req_wdata[w*DW +: DW];
            if (!req_we[w]) tagq.push_back(w);
            m_last = w;
        end else if (mem_ready) begin
            m_mv = 0;
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        req_valid = '0;
        mem_rsp_valid = 1'b0;
        mem_ready = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, '0);
        chk({tag, "_mem_valid"}, mem_valid, 1'b0);
        chk({tag, "_mem_we"}, mem_we, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, '0);
        chk({tag, "_mem_wdata"}, mem_wdata, '0);
        chk({tag, "_rsp_valid"}, rsp_valid, '0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, '0);
        chk({tag, "_err_out"}, err_out, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] route_exp [3];
        logic [DW-1:0] route_dat [3];
        logic [NR-1:0] cont_exp;

        route_exp[0] = 2'b01; route_exp[1] = 2'b10; route_exp[2] = 2'b01;
        route_dat[0] = 32'hAAAA_0001; route_dat[1] = 32'hBBBB_0002; route_dat[2] = 32'hCCCC_0003;

        // Reset with requests pending: grants must stay low.
        rst_in = 1'b1;
        req_valid = '1; req_we = '0;
        req_addr = 32'h5555_3333; req_wdata = 64'h1234_5678_9ABC_DEF0;
        mem_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rdata = '0;
        model_reset();
        #7;
        chk_all_zero("reset");
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        idle();

        // Single read, memory answers three cycles after accept.
        req_valid = 2'b01; req_we = 2'b00; req_addr[AW-1:0] = 16'h0010;
        cycle();
        chk("single_grant", last_ready, 2'b01);
        req_valid = '0;
        cycle();
        chk("single_mem_valid", last_mv, 1'b1);
        chk("single_mem_addr", last_addr, 16'h0010);
        cycle();
        cycle();
        mem_rsp_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
        cycle();
        mem_rsp_valid = 1'b0;
        cycle();
        chk("single_rsp_valid", last_rsp, 2'b01);
        chk("single_rsp_rdata", last_rdata, 32'hDEADBEEF);

        // Contention with writes held on both requesters.
        req_valid = 2'b11; req_we = 2'b11;
        for (int k = 0; k < 6; k++) begin
            req_wdata = {$urandom, $urandom};
            cycle();
            cont_exp = FIXED ? 2'b01 : ((k % 2 == 0) ? 2'b10 : 2'b01);
            chk("contention", last_ready, cont_exp);
        end
        idle();
        cycle();

        // Backpressure: payload held, no grants.
        req_valid = 2'b01; req_we = 2'b01;
        req_addr[AW-1:0] = 16'h1234; req_wdata[DW-1:0] = 32'hCAFEF00D;
        cycle();
        req_valid = 2'b11; req_addr = '0; req_wdata = '0; mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_ready", last_ready, 2'b00);
            chk("bp_addr", last_addr, 16'h1234);
            chk("bp_wdata", last_wdata, 32'hCAFEF00D);
            chk("bp_we", last_we, 1'b1);
        end
        idle();
        cycle();
        cycle();

        // Tag FIFO full: reads blocked, writes still pass, pop frees room at once.
        req_we = 2'b00;
        for (int k = 0; k < MO; k++) begin
            req_valid = 2'b01; req_addr[AW-1:0] = AW'(16'h0100 + k);
            cycle();
            chk("tagfill_grant", last_ready, 2'b01);
        end
        cycle();
        chk("tagfull_block", last_ready, 2'b00);
        req_valid = 2'b11; req_we = 2'b10; req_addr[2*AW-1:AW] = 16'h0BEE;
        cycle();
        chk("tagfull_write", last_ready, 2'b10);
        req_valid = 2'b01; req_we = 2'b00;
        mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_F00F;
        cycle();
        chk("tagfull_pop_grant", last_ready, 2'b01);
        req_valid = '0;
        for (int k = 0; k < MO; k++) begin
            mem_rdata = 32'h1000_0000 + k;
            cycle();
        end
        mem_rsp_valid = 1'b0;
        cycle();

        // Routing of interleaved reads.
        req_we = 2'b00;
        req_addr = {16'h00B0, 16'h00A0};
        req_valid = 2'b01; cycle();
        req_valid = 2'b10; cycle();
        req_addr[AW-1:0] = 16'h00C0;
        req_valid = 2'b01; cycle();
        req_valid = '0; cycle();
        for (int j = 0; j < 4; j++) begin
            mem_rsp_valid = (j < 3);
            if (j < 3) mem_rdata = route_dat[j];
            cycle();
            if (j > 0) begin
                chk("route_vld", last_rsp, route_exp[j-1]);
                chk("route_dat", last_rdata, route_dat[j-1]);
            end
        end

        // Reset with two reads outstanding, then a stray response.
        req_valid = 2'b01; cycle();
        req_valid = 2'b10; cycle();
        req_valid = 2'b11;
        rst_in = 1'b1;
        #1;
        chk_all_zero("midrst");
        model_reset();
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        idle();
        mem_rsp_valid = 1'b1; mem_rdata = 32'h5A5A_5A5A;
        cycle();
        mem_rsp_valid = 1'b0;
        cycle();
        chk("err_set", last_err, 1'b1);
        chk("err_no_rsp", last_rsp, 2'b00);
        cycle();
        chk("err_sticky", last_err, 1'b1);

        rst_in = 1'b1;
        #1;
        chk("err_cleared", err_out, 1'b0);
        model_reset();
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        // Randomized traffic with an in-order memory model.
        for (int n = 0; n < 3000; n++) begin
            req_valid = NR'($urandom);
            req_we = NR'($urandom);
            for (int i = 0; i < NR; i++) begin
                req_addr[i*AW +: AW] = AW'($urandom);
                req_wdata[i*DW +: DW] = $urandom;
            end
            mem_ready = ($urandom_range(0, 3) != 0);
            if (pend_n > 0 && $urandom_range(0, 1) == 1) begin
                mem_rsp_valid = 1'b1;
                mem_rdata = $urandom;
                pend_n--;
            end else begin
                mem_rsp_valid = 1'b0;
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
